// File: rtl/count_scheduler_if.sv
// count_scheduler_if: requester and shared-counter bundle for count_scheduler
interface count_scheduler_if #(
  parameter int NREQ = 4,
  parameter int CW = 4,
  parameter int IDW = $clog2(NREQ)
);
  logic [NREQ-1:0] req;
  logic [NREQ*CW-1:0] len;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0] gnt_id;
  logic busy;
  logic [NREQ-1:0] done;
  logic cnt_clr;
  logic cnt_en;
  logic [CW-1:0] cnt_q;
  modport master (output req, len, cnt_q, input gnt, gnt_id, busy, done, cnt_clr, cnt_en);
  modport slave (input req, len, cnt_q, output gnt, gnt_id, busy, done, cnt_clr, cnt_en);
endinterface

// File: rtl/count_scheduler.sv
// count_scheduler: round-robin arbiter sharing one external up-counter among NREQ requesters
module count_scheduler #(
  parameter int NREQ = 4,
  parameter int CW = 4,
  parameter int IDW = $clog2(NREQ)
) (
  input logic Clk,
  input logic Reset_n,
  count_scheduler_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0] state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d, ptr_q, ptr_d, win, idx;
  logic [CW-1:0] tgt_q, tgt_d;
  logic alive, hit;
  assign alive = bus.req[gnt_id_q];
  assign hit = bus.cnt_q == tgt_q;
  // descending scan so the nearest requester after ptr is written last
  always_comb begin
    win = ptr_q;
    idx = ptr_q;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (bus.req[idx]) win = idx;
    end
  end
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d = ptr_q;
    tgt_d = tgt_q;
    case (state_q)
      IDLE: if (|bus.req) begin
        state_d = LOAD;
        gnt_d = NREQ'(1) << win;
        gnt_id_d = win;
        tgt_d = bus.len[int'(win)*CW +: CW];
      end
      LOAD: state_d = alive ? RUN : IDLE;
      RUN: state_d = !alive ? IDLE : hit ? DONE : RUN;
      default: state_d = IDLE;
    endcase
    done_d = (state_q == RUN && alive && hit) ? gnt_q : '0;
    // leaving a run, whether completed or withdrawn, drops the grant and rotates priority
    if (state_d == IDLE && state_q != IDLE) begin
      gnt_d = '0;
      ptr_d = gnt_id_q;
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      gnt_id_q <= '0;
      done_q <= '0;
      ptr_q <= IDW'(NREQ - 1);
      tgt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      gnt_id_q <= gnt_id_d;
      done_q <= done_d;
      ptr_q <= ptr_d;
      tgt_q <= tgt_d;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.done = done_q;
  assign bus.busy = state_q != IDLE;
  assign bus.cnt_clr = state_q == LOAD;
  assign bus.cnt_en = state_q == RUN && alive && !hit;
endmodule

// File: tb/tb_count_scheduler.sv
// tb_count_scheduler: directed and random stimulus checked against a run-timeline reference model
module tb_count_scheduler;
  localparam int NREQ = 4;
  localparam int CW = 4;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic [CW-1:0] cnt = '0;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit m_busy = 0;
  int m_s = 0;
  int m_w = 0;
  int m_t = 0;
  int m_last = NREQ - 1;
  count_scheduler_if #(.NREQ(NREQ), .CW(CW)) bus ();
  count_scheduler #(.NREQ(NREQ), .CW(CW)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus.slave));
  always #5 Clk = ~Clk;
  // the shared counter that lives outside the scheduler
  always @(posedge Clk) begin
    if (bus.cnt_clr) cnt <= '0;
    else if (bus.cnt_en) cnt <= cnt + 1'b1;
  end
  assign bus.cnt_q = cnt;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 0);
    chk({tag, "_gnt_id"}, 32'(bus.gnt_id), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_clr"}, 32'(bus.cnt_clr), 0);
    chk({tag, "_en"}, 32'(bus.cnt_en), 0);
  endtask
  // one clock: drive inputs, check outputs against the run timeline, advance the model
  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*CW-1:0] l);
    logic [NREQ-1:0] eg, ed;
    logic eb, ec, ee;
    int k;
    @(posedge Clk);
    #1;
    bus.req = r;
    bus.len = l;
    #5;
    eg = '0;
    ed = '0;
    eb = 0;
    ec = 0;
    ee = 0;
    k = cyc - m_s;
    if (m_busy) begin
      eg = NREQ'(1) << m_w;
      eb = 1;
      ec = k == 1;
      ee = k >= 2 && k <= 1 + m_t && r[m_w];
      ed = (k == 3 + m_t) ? eg : '0;
      chk("gnt_id", 32'(bus.gnt_id), m_w);
      if (k == 3 + m_t) chk("cnt_at_done", 32'(cnt), m_t);
    end
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("busy", 32'(bus.busy), 32'(eb));
    chk("done", 32'(bus.done), 32'(ed));
    chk("cnt_clr", 32'(bus.cnt_clr), 32'(ec));
    chk("cnt_en", 32'(bus.cnt_en), 32'(ee));
    chk("clr_en_excl", 32'(bus.cnt_clr & bus.cnt_en), 0);
    if (m_busy) begin
      if (k == 3 + m_t || (!r[m_w] && k <= 2 + m_t)) begin
        m_busy = 0;
        m_last = m_w;
      end
    end else if (|r) begin
      for (int j = 1; j <= NREQ; j++) begin
        if (r[(m_last + j) % NREQ]) begin
          m_w = (m_last + j) % NREQ;
          break;
        end
      end
      m_busy = 1;
      m_s = cyc;
      m_t = int'(l[m_w*CW +: CW]);
    end
    cyc++;
  endtask
  task automatic run(input logic [NREQ-1:0] r, input logic [NREQ*CW-1:0] l, input int n);
    repeat (n) step(r, l);
  endtask
  function automatic logic [CW-1:0] rand_len();
    int r;
    r = $urandom_range(9, 0);
    return r == 0 ? '0 : r == 1 ? {CW{1'b1}} : CW'($urandom_range(6, 1));
  endfunction
  initial begin
    logic [NREQ-1:0] rq, pd;
    logic [NREQ*CW-1:0] ln;
    bus.req = '0;
    bus.len = '0;
    #12;
    chk_idle("reset");
    #1;
    Reset_n = 1'b1;
    run(4'b0001, 16'h0005, 12);
    run(4'b0000, 16'h0000, 2);
    run(4'b1111, 16'h2222, 36);
    run(4'b0000, 16'h0000, 3);
    run(4'b0001, 16'h0000, 5);
    run(4'b0000, 16'h0000, 2);
    run(4'b0001, 16'h000F, 20);
    run(4'b0000, 16'h0000, 2);
    run(4'b0001, 16'h001A, 1);
    run(4'b0011, 16'h001A, 3);
    run(4'b0010, 16'h001A, 8);
    run(4'b0000, 16'h0000, 2);
    run(4'b0001, 16'h000A, 6);
    @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    bus.req = '0;
    #1;
    chk_idle("async_rst");
    m_busy = 0;
    m_last = NREQ - 1;
    @(posedge Clk);
    #3;
    Reset_n = 1'b1;
    run(4'b1000, 16'h3000, 7);
    run(4'b0000, 16'h0000, 2);
    rq = '0;
    pd = '0;
    ln = '0;
    repeat (3000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rq[i]) begin
          if (pd[i]) rq[i] = $urandom_range(1, 0) == 1;
          else if ($urandom_range(39, 0) == 0) rq[i] = 1'b0;
        end else if ($urandom_range(5, 0) == 0) rq[i] = 1'b1;
        if ($urandom_range(7, 0) == 0) ln[i*CW +: CW] = rand_len();
      end
      step(rq, ln);
      pd = bus.done;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
